send_cam: RTL
=============

SEND_CAM -- requirements
Module: send_cam

Interface
REQ-001 SHALL have parameter H_ACT, default 640: active pixels per line (>=1).
REQ-002 SHALL have parameter V_ACT, default 480: active lines per frame (>=1).
REQ-003 SHALL have parameter H_BLANK, default 144: href-low cycles between lines (>=1).
REQ-004 SHALL have parameters VSYN_W, V_BACK, V_FRONT, defaults 16, 32, 16: vsync-high cycles, post-vsync cycles, post-last-line cycles (each >=1).
REQ-005 SHALL have port cmos_pclk  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port tx_en  in  1  frame-generation enable, sampled only in IDLE.
REQ-008 SHALL have port pat_en  in  1  1 = internal ramp pattern, 0 = pixel_data; sampled at frame start.
REQ-009 SHALL have port pixel_data  in  16  RGB565 pixel from upstream.
REQ-010 SHALL have port pixel_valid  in  1  pixel_data valid.
REQ-011 SHALL have port pixel_ready  out  1  block takes a pixel this cycle if pixel_valid=1.
REQ-012 SHALL have ports cmos_data out 8, cmos_href out 1, cmos_vsyn out 1: DVP camera bus, all registered.
REQ-013 SHALL have ports frame_done out 1 (1-cycle pulse), underflow out 1 (sticky), busy out 1 (state != IDLE).

Function
REQ-014 SHALL implement FSM IDLE -> VSYNC -> VBACK -> LINE -> (HBLANK -> LINE)* -> VFRONT -> VSYNC or IDLE.
REQ-015 IDLE: outputs low; tx_en=1 moves to VSYNC next cycle.
REQ-016 VSYNC: cmos_vsyn=1, cmos_href=0, cmos_data=0 for exactly VSYN_W cycles.
REQ-017 VBACK: vsyn=0, href=0, data=0 for exactly V_BACK cycles.
REQ-018 LINE: cmos_href=1 for exactly 2*H_ACT contiguous cycles; bytes alternate high byte [15:8] then low byte [7:0] of each pixel, high byte first.
REQ-019 HBLANK: href=0, data=0 for exactly H_BLANK cycles; entered after every line except line V_ACT-1.
REQ-020 After line V_ACT-1, SHALL enter VFRONT: href=0, vsyn=0, data=0 for exactly V_FRONT cycles.
REQ-021 End of VFRONT: frame_done=1 for one cycle; next state VSYNC if tx_en=1, else IDLE.
REQ-022 tx_en deasserted mid-frame SHALL NOT truncate the frame; frame completes.
REQ-023 Line timing SHALL never stall; href shape is fixed by parameters regardless of pixel_valid.
REQ-024 pixel_ready SHALL be 1 exactly in the cycle before each high-byte cycle (last cycle of VBACK/HBLANK, or a low-byte cycle not last in line), depend on registered state only, and be 0 when pat_en latched 1.
REQ-025 pixel_ready=1 and pixel_valid=1: pixel_data captured; its high byte appears on cmos_data next cycle, low byte the cycle after.
REQ-026 pixel_ready=1 and pixel_valid=0: block SHALL emit 16'h0000 for that pixel and set underflow=1 until reset.
REQ-027 pat_en latched 1: pixel value = {line_cnt[7:0], pix_cnt[7:0]}, line_cnt/pix_cnt zero-based, modulo 256.
REQ-028 Pixel and line counters SHALL be wide enough for H_ACT-1 and V_ACT-1; clear at line/frame start.
REQ-029 Total frame length SHALL be VSYN_W+V_BACK+2*H_ACT*V_ACT+H_BLANK*(V_ACT-1)+V_FRONT cycles.

Reset
REQ-030 rst=1 SHALL force next cycle: state IDLE, cmos_data=0, cmos_href=0, cmos_vsyn=0, pixel_ready=0, frame_done=0, underflow=0, busy=0, counters 0.
REQ-031 rst asserted mid-frame SHALL abort the frame without frame_done; after release, generation restarts at VSYNC only if tx_en=1.

Verification (H_ACT=4, V_ACT=2, H_BLANK=3, VSYN_W=2, V_BACK=3, V_FRONT=2; frame=26 cycles)
REQ-032 Reset then tx_en=1, pat_en=1 -> vsyn high 2 cycles, href high 8 cycles twice 3 cycles apart; line1 bytes 01,00,01,01,01,02,01,03; frame_done at cycle 26.
REQ-033 pat_en=0, pixel_valid always 1, pixels 16'hA1B2,16'hC3D4,... -> cmos_data A1,B2,C3,D4,... in href; underflow stays 0; 8 handshakes per frame.
REQ-034 pixel_valid=0 on 3rd pixel of line 0 -> bytes 00,00 there; underflow=1 and stays 1; href timing unchanged.
REQ-035 tx_en held 1 -> frames back-to-back, VSYNC immediately after frame_done; tx_en dropped mid-line -> frame finishes, then IDLE, busy=0.
REQ-036 rst pulsed during LINE -> next cycle all outputs 0, no frame_done; tx_en=1 after release -> fresh VSYNC.

Source files
------------

// File: rtl/send_cam_if.sv
// send_cam_if: upstream pixel stream into the DVP sender.
// pixel_data/pixel_valid from master, pixel_ready from slave.
interface send_cam_if;
    logic [15:0] pixel_data;
    logic        pixel_valid;
    logic        pixel_ready;

    modport master (
        output pixel_data,
        output pixel_valid,
        input  pixel_ready
    );

    modport slave (
        input  pixel_data,
        input  pixel_valid,
        output pixel_ready
    );
endinterface

// File: rtl/send_cam.sv
// send_cam: DVP camera-bus frame generator (RGB565, 2 bytes/pixel).
// Ports: cmos_pclk/rst, tx_en, pat_en, pix (pixel stream slave),
// cmos_data/href/vsyn (registered DVP bus), frame_done, underflow, busy.
module send_cam #(
    parameter int H_ACT   = 640,
    parameter int V_ACT   = 480,
    parameter int H_BLANK = 144,
    parameter int VSYN_W  = 16,
    parameter int V_BACK  = 32,
    parameter int V_FRONT = 16
) (
    input  logic         cmos_pclk,
    input  logic         rst,
    input  logic         tx_en,
    input  logic         pat_en,
    send_cam_if.slave    pix,
    output logic [7:0]   cmos_data,
    output logic         cmos_href,
    output logic         cmos_vsyn,
    output logic         frame_done,
    output logic         underflow,
    output logic         busy
);
    localparam int M1   = (VSYN_W > V_BACK) ? VSYN_W : V_BACK;
    localparam int M2   = (H_BLANK > V_FRONT) ? H_BLANK : V_FRONT;
    localparam int CMAX = (M1 > M2) ? M1 : M2;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int PW   = $clog2(H_ACT + 1);
    localparam int LW   = $clog2(V_ACT + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_VSYNC  = 3'd1;
    localparam logic [2:0] S_VBACK  = 3'd2;
    localparam logic [2:0] S_LINE   = 3'd3;
    localparam logic [2:0] S_HBLANK = 3'd4;
    localparam logic [2:0] S_VFRONT = 3'd5;

    logic [2:0]    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [PW-1:0] pix_cnt, pix_n;
    logic [LW-1:0] line_cnt, line_n;
    logic          lo, lo_n;
    logic          pat_lat, pat_n;
    logic [7:0]    pix_lo;
    logic [15:0]   val;
    logic          load;

    // lo=1 marks the low-byte cycle of the current pixel
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pix_n   = pix_cnt;
        line_n  = line_cnt;
        lo_n    = lo;
        pat_n   = pat_lat;
        unique case (state)
            S_IDLE: begin
                if (tx_en) begin
                    state_n = S_VSYNC;
                    cnt_n   = '0;
                    pat_n   = pat_en;
                end
            end
            S_VSYNC: begin
                cnt_n = cnt + 1'b1;
                if (cnt == CW'(VSYN_W - 1)) begin
                    state_n = S_VBACK;
                    cnt_n   = '0;
                end
            end
            S_VBACK: begin
                cnt_n = cnt + 1'b1;
                if (cnt == CW'(V_BACK - 1)) begin
                    state_n = S_LINE;
                    pix_n   = '0;
                    line_n  = '0;
                    lo_n    = 1'b0;
                end
            end
            S_LINE: begin
                if (!lo) begin
                    lo_n = 1'b1;
                end else if (pix_cnt != PW'(H_ACT - 1)) begin
                    pix_n = pix_cnt + 1'b1;
                    lo_n  = 1'b0;
                end else begin
                    cnt_n = '0;
                    lo_n  = 1'b0;
                    if (line_cnt == LW'(V_ACT - 1)) begin
                        state_n = S_VFRONT;
                    end else begin
                        state_n = S_HBLANK;
                        line_n  = line_cnt + 1'b1;
                    end
                end
            end
            S_HBLANK: begin
                cnt_n = cnt + 1'b1;
                if (cnt == CW'(H_BLANK - 1)) begin
                    state_n = S_LINE;
                    pix_n   = '0;
                    lo_n    = 1'b0;
                end
            end
            S_VFRONT: begin
                cnt_n = cnt + 1'b1;
                if (cnt == CW'(V_FRONT - 1)) begin
                    cnt_n  = '0;
                    line_n = '0;
                    if (tx_en) begin
                        state_n = S_VSYNC;
                        pat_n   = pat_en;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Ready in the cycle before every high-byte cycle; never stalls.
    assign pix.pixel_ready = !pat_lat && (
        (state == S_VBACK && cnt == CW'(V_BACK - 1)) ||
        (state == S_HBLANK && cnt == CW'(H_BLANK - 1)) ||
        (state == S_LINE && lo && pix_cnt != PW'(H_ACT - 1)));

    assign frame_done = (state == S_VFRONT) &&
                        (cnt == CW'(V_FRONT - 1));
    assign busy = (state != S_IDLE);

    // Pattern uses the indices of the pixel about to be sent
    always_comb begin
        if (pat_lat)
            val = {8'(line_n), 8'(pix_n)};
        else if (pix.pixel_valid)
            val = pix.pixel_data;
        else
            val = 16'h0000;
    end

    assign load = (state_n == S_LINE) && !lo_n;

    always_ff @(posedge cmos_pclk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            pix_cnt   <= '0;
            line_cnt  <= '0;
            lo        <= 1'b0;
            pat_lat   <= 1'b0;
            pix_lo    <= 8'h00;
            cmos_data <= 8'h00;
            cmos_href <= 1'b0;
            cmos_vsyn <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            pix_cnt   <= pix_n;
            line_cnt  <= line_n;
            lo        <= lo_n;
            pat_lat   <= pat_n;
            cmos_vsyn <= (state_n == S_VSYNC);
            cmos_href <= (state_n == S_LINE);
            if (load) begin
                cmos_data <= val[15:8];
                pix_lo    <= val[7:0];
            end else if (state_n == S_LINE) begin
                cmos_data <= pix_lo;
            end else begin
                cmos_data <= 8'h00;
            end
            if (pix.pixel_ready && !pix.pixel_valid)
                underflow <= 1'b1;
        end
    end
endmodule
